// File: rtl/sum_acc_pkg.sv
// Shared types and default widths for the sum accumulator.
// Optional build macro used by this block: SUM_ACCUMULATOR_SAT_EN (saturating adds).
package sum_acc_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ACC_W  = 12;
  localparam int DEF_CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/acc_add.sv
// Combinational accumulator adder with carry out.
// SUM_ACCUMULATOR_SAT_EN defined: a carrying add clamps the sum to all-ones; otherwise it wraps.
module acc_add #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 12
) (
  input  logic [ACC_W-1:0]  acc_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic              carry_o
);

  logic [ACC_W:0] full;

  assign full    = {1'b0, acc_i} + (ACC_W+1)'(data_i);
  assign carry_o = full[ACC_W];

`ifdef SUM_ACCUMULATOR_SAT_EN
  assign sum_o = carry_o ? {ACC_W{1'b1}} : full[ACC_W-1:0];
`else
  assign sum_o = full[ACC_W-1:0];
`endif

endmodule

// File: rtl/sum_accumulator.sv
// Burst accumulator: sums len samples, then presents the result until accepted.
// state | meaning: IDLE wait for start | ACCUM take samples | DONE hold result. Macro: SUM_ACCUMULATOR_SAT_EN.
module sum_accumulator
  import sum_acc_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_ovf,
  output logic              busy
);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d, sum;
  logic [CNT_W:0]   cnt_q, cnt_d, len_q, len_d, cnt_inc;
  logic             ovf_q, ovf_d, carry, xfer, last;

  acc_add #(
    .DATA_W(DATA_W),
    .ACC_W (ACC_W)
  ) u_add (
    .acc_i  (acc_q),
    .data_i (in_data),
    .sum_o  (sum),
    .carry_o(carry)
  );

  assign xfer    = (state_q == ACCUM) && in_valid;
  assign cnt_inc = cnt_q + (CNT_W+1)'(1);
  assign last    = (cnt_inc == len_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start)        state_d = ACCUM;
      ACCUM:   if (xfer && last) state_d = DONE;
      DONE:    if (out_ready)    state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ACCUM);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
  end

  // len of zero encodes a full 2**CNT_W burst, hence the extra count bit
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    len_d = len_q;
    ovf_d = ovf_q;
    if (state_q == IDLE && start) begin
      acc_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
      len_d = (len == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, len};
    end else if (xfer) begin
      acc_d = sum;
      cnt_d = cnt_inc;
      ovf_d = ovf_q | carry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
      len_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      len_q <= len_d;
      ovf_q <= ovf_d;
    end
  end

  assign out_data = acc_q;
  assign out_ovf  = ovf_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Self-checking bench for sum_accumulator: a default-width instance and an ACC_W=10 instance share stimulus.
// Expected results follow SUM_ACCUMULATOR_SAT_EN when the build defines it.
module tb_sum_accumulator;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] len;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;

  logic        in_ready, out_valid, out_ovf, busy;
  logic [11:0] out_data;
  logic        in_ready10, out_valid10, out_ovf10, busy10;
  logic [9:0]  out_data10;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] smp_buf [16];

  sum_accumulator dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ovf(out_ovf), .busy(busy)
  );

  sum_accumulator #(.ACC_W(10)) dut10 (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready10),
    .out_valid(out_valid10), .out_ready(out_ready), .out_data(out_data10),
    .out_ovf(out_ovf10), .busy(busy10)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: result of a burst is the plain sum, wrapped or clamped to w bits.
  function automatic void model(input int unsigned total, input int w,
                                output logic [31:0] d, output logic o);
    int unsigned lim;
    lim = 32'd1 << w;
    o   = (total >= lim);
`ifdef SUM_ACCUMULATOR_SAT_EN
    d = o ? lim - 1 : total;
`else
    d = total % lim;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // gap_mode: 0 back-to-back, 1 idle cycle before every sample, 2 random idles
  task automatic run_burst(input logic [3:0] l, input int n, input int gap_mode,
                           output int unsigned total);
    total = 0;
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    for (int i = 0; i < n; i++) begin
      if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 2) == 0)) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        tick();
        check("stall_not_done", out_valid, 0);
      end
      in_valid = 1'b1;
      in_data  = smp_buf[i];
      total   += smp_buf[i];
      check("in_ready_accum", in_ready, 1);
      tick();
    end
    in_valid = 1'b0;
    check("out_valid_latency", out_valid, 1);
    check("out_valid10_latency", out_valid10, 1);
    check("in_ready_done", in_ready, 0);
  endtask

  task automatic finish_burst(input int hold);
    out_ready = 1'b0;
    repeat (hold) begin
      tick();
      check("hold_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("idle_out_valid", out_valid, 0);
    check("idle_busy", busy, 0);
  endtask

  typedef struct packed {
    logic [3:0]  len;
    logic [4:0]  n;
    logic [7:0]  base;
    logic [7:0]  step;
    logic [11:0] exp_data;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int unsigned total;
    logic [31:0] ed;
    logic        eo;

    rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    vecs[0] = '{4'd3,  5'd3,  8'd10,  8'd10, 12'd60,   1'b0};
    vecs[1] = '{4'd0,  5'd16, 8'd255, 8'd0,  12'd4080, 1'b0};
    vecs[2] = '{4'd1,  5'd1,  8'd0,   8'd0,  12'd0,    1'b0};
    vecs[3] = '{4'd7,  5'd7,  8'd1,   8'd2,  12'd49,   1'b0};
    vecs[4] = '{4'd15, 5'd15, 8'd200, 8'd3,  12'd3315, 1'b0};

    #3;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_ovf", out_ovf, 0);
    check("rst_busy", busy, 0);
    check("rst_busy10", busy10, 0);
    tick();
    rst = 1'b0;

    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < 16; i++) smp_buf[i] = 8'(vecs[v].base + i * vecs[v].step);
      run_burst(vecs[v].len, int'(vecs[v].n), 0, total);
      check("vec_out_data", out_data, vecs[v].exp_data);
      check("vec_out_ovf", out_ovf, vecs[v].exp_ovf);
      finish_burst(v % 3);
      check("vec_idle_hold_data", out_data, vecs[v].exp_data);
    end

    // five 255s: 1275 overflows a 10-bit accumulator but not a 12-bit one
    for (int i = 0; i < 16; i++) smp_buf[i] = 8'd255;
    run_burst(4'd5, 5, 0, total);
    check("w12_1275_data", out_data, 1275);
    check("w12_1275_ovf", out_ovf, 0);
`ifdef SUM_ACCUMULATOR_SAT_EN
    check("w10_1275_data", out_data10, 1023);
`else
    check("w10_1275_data", out_data10, 251);
`endif
    check("w10_1275_ovf", out_ovf10, 1);
    finish_burst(0);

    // result held under backpressure; extra samples and start ignored
    smp_buf[0] = 8'd5; smp_buf[1] = 8'd7;
    run_burst(4'd2, 2, 0, total);
    in_valid = 1'b1; in_data = 8'd99;
    for (int c = 0; c < 4; c++) begin
      start = (c == 1);
      len   = 4'd1;
      tick();
      start = 1'b0;
      check("bp_out_data", out_data, 12);
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_idle_busy", busy, 0);
    check("bp_idle_data", out_data, 12);

    // reset mid-burst discards the partial sum
    start = 1'b1; len = 4'd4;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_data = 8'd40;
    tick();
    in_data = 8'd50;
    tick();
    check("pre_rst_acc", out_data, 90);
    rst = 1'b1;
    #1;
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_out_ovf", out_ovf, 0);
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    smp_buf[0] = 8'd9;
    run_burst(4'd1, 1, 0, total);
    check("post_rst_data", out_data, 9);
    finish_burst(1);

    // alternating in_valid: exactly three transfers
    smp_buf[0] = 8'd1; smp_buf[1] = 8'd2; smp_buf[2] = 8'd3;
    run_burst(4'd3, 3, 1, total);
    in_valid = 1'b1; in_data = 8'd77;
    tick();
    in_valid = 1'b0;
    check("gap_out_data", out_data, 6);
    finish_burst(0);

    // randomized bursts against the arithmetic model
    for (int b = 0; b < 30; b++) begin
      logic [3:0] l;
      int n;
      l = 4'($urandom_range(0, 15));
      n = (l == 0) ? 16 : int'(l);
      for (int i = 0; i < 16; i++) smp_buf[i] = 8'($urandom);
      run_burst(l, n, 2, total);
      model(total, 12, ed, eo);
      check("rnd_w12_data", out_data, ed);
      check("rnd_w12_ovf", out_ovf, eo);
      model(total, 10, ed, eo);
      check("rnd_w10_data", out_data10, ed);
      check("rnd_w10_ovf", out_ovf10, eo);
      finish_burst(int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
